// File: rtl/multi_mode_register.sv
// General-purpose datapath register: hold/load/clear/inc/dec/shift/rotate with
// registered carry and zero flags. Optional saturation for inc/dec.
module multi_mode_register #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
    parameter bit                    SATURATE    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_CLEAR = 3'b010,
        MODE_INC   = 3'b011,
        MODE_DEC   = 3'b100,
        MODE_SHL   = 3'b101,
        MODE_SHR   = 3'b110,
        MODE_ROL   = 3'b111
    } mode_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    mode_e            mode_sel;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    assign mode_sel = mode_e'(mode);

    always_comb begin
        out_d   = out_q;
        carry_d = carry_q;
        case (mode_sel)
            MODE_HOLD: begin
                out_d   = out_q;
                carry_d = carry_q;
            end
            MODE_LOAD: begin
                out_d   = data;
                carry_d = 1'b0;
            end
            MODE_CLEAR: begin
                out_d   = '0;
                carry_d = 1'b0;
            end
            MODE_INC: begin
                carry_d = (out_q == '1);
                // Saturating mode pins the value at all-ones and reports overflow via carry
                if (SATURATE && (out_q == '1)) out_d = out_q;
                else                            out_d = out_q + ONE;
            end
            MODE_DEC: begin
                carry_d = (out_q == '0);
                if (SATURATE && (out_q == '0)) out_d = out_q;
                else                            out_d = out_q - ONE;
            end
            MODE_SHL: begin
                out_d   = {out_q[WIDTH-2:0], serial_in};
                carry_d = out_q[WIDTH-1];
            end
            MODE_SHR: begin
                out_d   = {serial_in, out_q[WIDTH-1:1]};
                carry_d = out_q[0];
            end
            MODE_ROL: begin
                out_d   = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                carry_d = out_q[WIDTH-1];
            end
            default: begin
                out_d   = out_q;
                carry_d = carry_q;
            end
        endcase
        zero_d = (out_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= RESET_VALUE;
            carry_q <= 1'b0;
            zero_q  <= (RESET_VALUE == '0);
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign out   = out_q;
    assign carry = carry_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_multi_mode_register.sv
// Directed bench for multi_mode_register: a wrapping and a saturating instance
// share stimulus; each result is packed as {out, carry, zero}.
module tb_multi_mode_register;

    logic       clk;
    logic       reset;
    logic [2:0] mode;
    logic [7:0] data;
    logic       serial_in;

    logic [7:0] w_out, s_out;
    logic       w_carry, s_carry, w_zero, s_zero;

    int unsigned n_checks;
    int unsigned n_fail;

    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, CLR = 3'b010, INC = 3'b011,
                           DEC = 3'b100, SHL = 3'b101, SHR = 3'b110, ROL = 3'b111;

    multi_mode_register #(.WIDTH(8), .RESET_VALUE(8'h5A), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .mode(mode), .data(data), .serial_in(serial_in),
        .out(w_out), .carry(w_carry), .zero(w_zero)
    );

    multi_mode_register #(.WIDTH(8), .RESET_VALUE(8'h5A), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .mode(mode), .data(data), .serial_in(serial_in),
        .out(s_out), .carry(s_carry), .zero(s_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got out=%h c=%b z=%b, expected out=%h c=%b z=%b",
                     tag, obs[9:2], obs[1], obs[0], exp[9:2], exp[1], exp[0]);
        end
    endtask

    // Apply one operation, let one rising edge pass, return at the falling edge.
    task automatic step(input logic [2:0] m, input logic [7:0] d, input logic si);
        mode      = m;
        data      = d;
        serial_in = si;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        mode      = HOLD;
        data      = 8'h00;
        serial_in = 1'b0;

        // Asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        check("rst_async_w", {w_out, w_carry, w_zero}, {8'h5A, 1'b0, 1'b0});
        check("rst_async_s", {s_out, s_carry, s_zero}, {8'h5A, 1'b0, 1'b0});
        // Inputs ignored while reset is held across an edge
        mode = LOAD; data = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_w", {w_out, w_carry, w_zero}, {8'h5A, 1'b0, 1'b0});
        reset = 1'b0;

        step(LOAD, 8'h00, 1'b0);
        check("load00_w", {w_out, w_carry, w_zero}, {8'h00, 1'b0, 1'b1});
        check("load00_s", {s_out, s_carry, s_zero}, {8'h00, 1'b0, 1'b1});
        for (int i = 0; i < 3; i++) begin
            step(HOLD, 8'hFF, 1'b1);
            check($sformatf("hold%0d_w", i), {w_out, w_carry, w_zero}, {8'h00, 1'b0, 1'b1});
        end

        step(LOAD, 8'hFE, 1'b0);
        step(INC, 8'h00, 1'b0);
        check("inc_fe_w", {w_out, w_carry, w_zero}, {8'hFF, 1'b0, 1'b0});
        check("inc_fe_s", {s_out, s_carry, s_zero}, {8'hFF, 1'b0, 1'b0});
        step(INC, 8'h00, 1'b0);
        check("inc_wrap_w", {w_out, w_carry, w_zero}, {8'h00, 1'b1, 1'b1});
        check("inc_sat_s", {s_out, s_carry, s_zero}, {8'hFF, 1'b1, 1'b0});
        step(HOLD, 8'h00, 1'b0);
        check("hold_carry_w", {w_out, w_carry, w_zero}, {8'h00, 1'b1, 1'b1});

        step(LOAD, 8'hFF, 1'b0);
        step(INC, 8'h00, 1'b0);
        check("inc_ff_s", {s_out, s_carry, s_zero}, {8'hFF, 1'b1, 1'b0});

        step(LOAD, 8'h00, 1'b0);
        step(DEC, 8'h00, 1'b0);
        check("dec_00_w", {w_out, w_carry, w_zero}, {8'hFF, 1'b1, 1'b0});
        check("dec_00_s", {s_out, s_carry, s_zero}, {8'h00, 1'b1, 1'b1});
        step(DEC, 8'h00, 1'b0);
        check("dec_ff_w", {w_out, w_carry, w_zero}, {8'hFE, 1'b0, 1'b0});
        step(LOAD, 8'h05, 1'b0);
        step(DEC, 8'h00, 1'b0);
        check("dec_05_s", {s_out, s_carry, s_zero}, {8'h04, 1'b0, 1'b0});
        step(LOAD, 8'h01, 1'b0);
        step(DEC, 8'h00, 1'b0);
        check("dec_01_w", {w_out, w_carry, w_zero}, {8'h00, 1'b0, 1'b1});

        step(LOAD, 8'b1000_0001, 1'b0);
        step(SHL, 8'h00, 1'b0);
        check("shl_w", {w_out, w_carry, w_zero}, {8'b0000_0010, 1'b1, 1'b0});
        step(SHR, 8'h00, 1'b1);
        check("shr_w", {w_out, w_carry, w_zero}, {8'b1000_0001, 1'b0, 1'b0});
        step(ROL, 8'h00, 1'b0);
        check("rol_w", {w_out, w_carry, w_zero}, {8'b0000_0011, 1'b1, 1'b0});
        step(ROL, 8'h00, 1'b1);
        check("rol_si_w", {w_out, w_carry, w_zero}, {8'b0000_0110, 1'b0, 1'b0});
        step(SHR, 8'h00, 1'b0);
        check("shr0_s", {s_out, s_carry, s_zero}, {8'b0000_0011, 1'b0, 1'b0});

        step(CLR, 8'hAA, 1'b1);
        check("clear_w", {w_out, w_carry, w_zero}, {8'h00, 1'b0, 1'b1});

        // Reset in the middle of a counting run
        step(LOAD, 8'h10, 1'b0);
        for (int i = 0; i < 3; i++) step(INC, 8'h00, 1'b0);
        check("inc_run_w", {w_out, w_carry, w_zero}, {8'h13, 1'b0, 1'b0});
        #1 reset = 1'b1;
        #1;
        check("rst_mid_w", {w_out, w_carry, w_zero}, {8'h5A, 1'b0, 1'b0});
        check("rst_mid_s", {s_out, s_carry, s_zero}, {8'h5A, 1'b0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_held_w", {w_out, w_carry, w_zero}, {8'h5A, 1'b0, 1'b0});
        reset = 1'b0;
        step(INC, 8'h00, 1'b0);
        check("inc_after_rst_w", {w_out, w_carry, w_zero}, {8'h5B, 1'b0, 1'b0});
        check("inc_after_rst_s", {s_out, s_carry, s_zero}, {8'h5B, 1'b0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
